leaf_stream_bridge: RTL and testbench
=====================================

Name: leaf_stream_bridge

Overview:
- Parametrised buffered bridge between the user side of leaf_interface and a user compute core (e.g. picorv32_wrapper).
- Generalises the direct wire-up to NUM_IN_PORTS upstream and NUM_OUT_PORTS downstream channels, each with a FIFO of depth FIFO_DEPTH.
- Adds run control: ap_start gates core reset, input presentation and a drain phase that flushes core output before reporting done.

Parameters:
- PAYLOAD_BITS, 32, data width per channel.
- NUM_IN_PORTS, 1, channels interface→core (1..8).
- NUM_OUT_PORTS, 2, channels core→interface (1..8).
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2.
- DRAIN_CYCLES, 16, consecutive idle cycles required in DRAIN before done (≥1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ap_start  in  1  run request, level-sensitive.
- core_resetn  out  1  active-low reset to user core.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on DRAIN→IDLE.
- up_din  in  NUM_IN_PORTS*PAYLOAD_BITS  from leaf_interface dout_leaf_interface2user; channel i at bits [i*W +: W].
- up_vld  in  NUM_IN_PORTS  from vld_interface2user.
- up_ack  out  NUM_IN_PORTS  to ack_user2interface.
- core_din  out  NUM_IN_PORTS*PAYLOAD_BITS  to core inputs.
- core_val_in  out  NUM_IN_PORTS  valid to core.
- core_ready_upward  in  NUM_IN_PORTS  core ready.
- core_dout  in  NUM_OUT_PORTS*PAYLOAD_BITS  core outputs.
- core_val_out  in  NUM_OUT_PORTS  core output valid.
- core_ready_downward  out  NUM_OUT_PORTS  ready to core.
- dn_dout  out  NUM_OUT_PORTS*PAYLOAD_BITS  to din_leaf_user2interface.
- dn_vld  out  NUM_OUT_PORTS  to vld_user2interface.
- dn_ack  in  NUM_OUT_PORTS  from ack_interface2user.

Behaviour:
- Handshake on every channel: a transfer occurs in a cycle where valid and ack/ready are both high. Valid, once high, holds with stable data until the transfer; the bridge itself obeys this rule.
- Each channel has one FIFO:
  - ready/ack = not full; valid = not empty.
  - Write in cycle N makes the word visible at the output in cycle N+1. There is no combinational bypass, including when the FIFO is empty.
  - Push and pop in the same cycle are allowed at any non-full count; the count is unchanged.
  - When full, ready is low even if a pop occurs that cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, RUN, DRAIN, held in a state register.
  - IDLE→RUN when ap_start=1.
  - RUN→DRAIN when ap_start=0.
  - DRAIN→RUN when ap_start=1; the idle counter clears.
  - DRAIN→IDLE when the idle counter reaches DRAIN_CYCLES. On that transition, done pulses for exactly one cycle in the first IDLE cycle.
- Idle counter:
  - Increments in DRAIN on each cycle where all downstream FIFOs are empty and core_val_out is all zero.
  - Any other DRAIN cycle resets it to 0.
  - Saturates at DRAIN_CYCLES.
- core_resetn = 1 in RUN and DRAIN, 0 in IDLE. It is decoded from the state register, so it rises the cycle after ap_start is sampled high.
- busy = (state != IDLE).
- Upstream path:
  - up_ack follows FIFO fullness in all states, so leaf_interface may preload data during IDLE.
  - core_val_in is forced to 0 outside RUN. No pop occurs outside RUN.
- Downstream path:
  - core_ready_downward is forced to 0 in IDLE and follows FIFO fullness in RUN and DRAIN.
  - dn_vld follows FIFO non-empty in all states, so residual words keep emptying in IDLE.
- Reset (async assert, sync deassert handled externally):
  - State goes to IDLE and all FIFO pointers and counts clear.
  - Outputs: core_resetn=0, busy=0, done=0, all valid and ready outputs 0, data outputs 0.
  - Reset mid-transfer discards all buffered words.
- Channels are independent; one channel being full or stalled never blocks another.

Decomposition:
- Package leaf_bridge_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a helper function for clog2 of FIFO_DEPTH.
- Sub-module leaf_stream_fifo: single-channel synchronous FIFO parametrised by PAYLOAD_BITS and FIFO_DEPTH. It has push/pop handshakes, a registered count, and uses clk/resetn. It is instantiated by a generate loop NUM_IN_PORTS + NUM_OUT_PORTS times.

Test Plan:
- Reset then ap_start=1 at cycle 5 → core_resetn=1 and busy=1 from cycle 6. Push 0xDEADBEEF on up ch0 at cycle 7 → core_val_in[0]=1 with core_din=0xDEADBEEF at cycle 8.
- IDLE preload, FIFO_DEPTH=4: push 5 words on up ch0 → up_ack drops after the 4th, core_val_in stays 0. On ap_start, words 1..4 are delivered in order, then the 5th is accepted.
- RUN, hold dn_ack[1]=0 and core pushes 4 words on dn ch1 → core_ready_downward[1]=0 after 4 words while ch0 still flows. Release dn_ack → words emerge in order, one per cycle.
- Full-FIFO push+pop: count=4, dn_ack=1 and core_val_out=1 in the same cycle → the pop occurs, the push is refused, and the count becomes 3.
- Drain: ap_start=0 with 2 words queued on dn ch0 and dn_ack=1 → both words emptied, then done pulses exactly DRAIN_CYCLES=16 cycles after the FIFO empties. core_resetn falls in the same cycle. ap_start=1 at idle-count 10 → return to RUN with no done pulse.
- Assert resetn=0 mid-burst with 3 words buffered → all valids drop immediately (async). After release, no stale word appears.

Source files
------------

// File: rtl/leaf_bridge_pkg.sv
// Shared types and helpers for the leaf_interface <-> user core stream bridge.
package leaf_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } bridge_state_t;

  // Ceiling log2, usable in constant expressions (parameters, port widths).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// Single-channel synchronous FIFO with valid/ready on both sides and no
// write-to-read bypass: a pushed word is visible on the cycle after the push.
module leaf_stream_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] push_data,
  input  logic                    push_valid,
  output logic                    push_ready,
  output logic [PAYLOAD_BITS-1:0] pop_data,
  output logic                    pop_valid,
  input  logic                    pop_ready
);

  // Handshake: a word moves when valid and ready are both high in the same
  // cycle; the producer holds valid and data stable until that cycle.

  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    do_push;
  logic                    do_pop;

  // Ready stays low while in reset; a full FIFO refuses a push even if it pops.
  assign push_ready = resetn && (count != FULL_COUNT);
  assign pop_valid  = (count != '0);
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Buffered bridge between the leaf_interface user side and a compute core,
// with run control (IDLE/RUN/DRAIN) that gates core reset and flushes output.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int DRAIN_CYCLES  = 16
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  ap_start,
  output logic                                  core_resetn,
  output logic                                  busy,
  output logic                                  done,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  up_din,
  input  logic [NUM_IN_PORTS-1:0]               up_vld,
  output logic [NUM_IN_PORTS-1:0]               up_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  core_din,
  output logic [NUM_IN_PORTS-1:0]               core_val_in,
  input  logic [NUM_IN_PORTS-1:0]               core_ready_upward,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] core_dout,
  input  logic [NUM_OUT_PORTS-1:0]              core_val_out,
  output logic [NUM_OUT_PORTS-1:0]              core_ready_downward,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dn_dout,
  output logic [NUM_OUT_PORTS-1:0]              dn_vld,
  input  logic [NUM_OUT_PORTS-1:0]              dn_ack,
  output bridge_state_t                         state_dbg
);

  localparam int CW = clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(DRAIN_CYCLES - 1);

  bridge_state_t                state;
  logic [CW-1:0]                idle_cnt;
  logic                         in_run;
  logic                         active;
  logic                         quiet;
  logic [NUM_IN_PORTS-1:0]      up_pop_valid;
  logic [NUM_OUT_PORTS-1:0]     dn_push_ready;

  assign in_run      = (state == ST_RUN);
  assign active      = (state != ST_IDLE);
  assign core_resetn = active;
  assign busy        = active;
  assign state_dbg   = state;
  assign quiet       = (dn_vld == '0) && (core_val_out == '0);

  assign core_val_in         = up_pop_valid & {NUM_IN_PORTS{in_run}};
  assign core_ready_downward = dn_push_ready & {NUM_OUT_PORTS{active}};

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_up
    leaf_stream_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push_data (up_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .push_valid(up_vld[i]),
      .push_ready(up_ack[i]),
      .pop_data  (core_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_valid (up_pop_valid[i]),
      .pop_ready (core_ready_upward[i] && in_run)
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_dn
    leaf_stream_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push_data (core_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .push_valid(core_val_out[j] && active),
      .push_ready(dn_push_ready[j]),
      .pop_data  (dn_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_valid (dn_vld[j]),
      .pop_ready (dn_ack[j])
    );
  end

  // The exit fires on the quiet cycle whose increment would make the counter
  // reach DRAIN_CYCLES, so done lands in the first IDLE cycle after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ap_start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!ap_start) begin
            state    <= ST_DRAIN;
            idle_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (ap_start) begin
            state    <= ST_RUN;
            idle_cnt <= '0;
          end else if (!quiet) begin
            idle_cnt <= '0;
          end else if (idle_cnt == LAST_IDLE) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            done     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Randomized and directed bench for leaf_stream_bridge against a queue-based
// transaction model of the channels and run control.
module tb_leaf_stream_bridge;
  import leaf_bridge_pkg::*;

  localparam int W     = 32;
  localparam int NI    = 1;
  localparam int NO    = 2;
  localparam int DEPTH = 4;
  localparam int DRAIN = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            ap_start = 1'b0;
  logic            core_resetn, busy, done;
  logic [NI*W-1:0] up_din = '0;
  logic [NI-1:0]   up_vld = '0;
  logic [NI-1:0]   up_ack;
  logic [NI*W-1:0] core_din;
  logic [NI-1:0]   core_val_in;
  logic [NI-1:0]   core_ready_upward = '0;
  logic [NO*W-1:0] core_dout = '0;
  logic [NO-1:0]   core_val_out = '0;
  logic [NO-1:0]   core_ready_downward;
  logic [NO*W-1:0] dn_dout;
  logic [NO-1:0]   dn_vld;
  logic [NO-1:0]   dn_ack = '0;
  bridge_state_t   state_dbg;

  leaf_stream_bridge #(
    .PAYLOAD_BITS (W),
    .NUM_IN_PORTS (NI),
    .NUM_OUT_PORTS(NO),
    .FIFO_DEPTH   (DEPTH),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .ap_start           (ap_start),
    .core_resetn        (core_resetn),
    .busy               (busy),
    .done               (done),
    .up_din             (up_din),
    .up_vld             (up_vld),
    .up_ack             (up_ack),
    .core_din           (core_din),
    .core_val_in        (core_val_in),
    .core_ready_upward  (core_ready_upward),
    .core_dout          (core_dout),
    .core_val_out       (core_val_out),
    .core_ready_downward(core_ready_downward),
    .dn_dout            (dn_dout),
    .dn_vld             (dn_vld),
    .dn_ack             (dn_ack),
    .state_dbg          (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard state ----------------
  logic [W-1:0] up_exp_q [NI][$];
  logic [W-1:0] dn_exp_q [NO][$];
  logic [W-1:0] up_src_q [NI][$];
  logic [W-1:0] dn_src_q [NO][$];
  int   m_mode;
  int   m_quiet;
  logic m_done;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin up_exp_q[i].delete(); up_src_q[i].delete(); end
    for (int j = 0; j < NO; j++) begin dn_exp_q[j].delete(); dn_src_q[j].delete(); end
    m_mode  = M_IDLE;
    m_quiet = 0;
    m_done  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [NI-1:0]   e_ack, e_cvi;
    logic [NI*W-1:0] e_cdin;
    logic [NO-1:0]   e_crd, e_dvld;
    logic [NO*W-1:0] e_dout;
    e_ack = '0; e_cvi = '0; e_cdin = '0; e_crd = '0; e_dvld = '0; e_dout = '0;
    for (int i = 0; i < NI; i++) begin
      e_ack[i] = (up_exp_q[i].size() < DEPTH);
      e_cvi[i] = (m_mode == M_RUN) && (up_exp_q[i].size() != 0);
      if (up_exp_q[i].size() != 0) e_cdin[i*W +: W] = up_exp_q[i][0];
    end
    for (int j = 0; j < NO; j++) begin
      e_crd[j]  = (m_mode != M_IDLE) && (dn_exp_q[j].size() < DEPTH);
      e_dvld[j] = (dn_exp_q[j].size() != 0);
      if (dn_exp_q[j].size() != 0) e_dout[j*W +: W] = dn_exp_q[j][0];
    end
    check("up_ack", up_ack, e_ack);
    check("core_val_in", core_val_in, e_cvi);
    check("core_din", core_din, e_cdin);
    check("core_ready_downward", core_ready_downward, e_crd);
    check("dn_vld", dn_vld, e_dvld);
    check("dn_dout", dn_dout, e_dout);
    check("core_resetn", core_resetn, m_mode != M_IDLE);
    check("busy", busy, m_mode != M_IDLE);
    check("done", done, m_done);
  endtask

  // Applies one clock edge worth of transfers and run-control rules.
  task automatic model_edge();
    logic quiet, rdy, vld;
    quiet = (core_val_out == '0);
    for (int j = 0; j < NO; j++) if (dn_exp_q[j].size() != 0) quiet = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rdy = (up_exp_q[i].size() < DEPTH);
      vld = (m_mode == M_RUN) && (up_exp_q[i].size() != 0);
      if (vld && core_ready_upward[i]) void'(up_exp_q[i].pop_front());
      if (up_vld[i] && rdy) begin
        up_exp_q[i].push_back(up_din[i*W +: W]);
        void'(up_src_q[i].pop_front());
      end
    end
    for (int j = 0; j < NO; j++) begin
      rdy = (m_mode != M_IDLE) && (dn_exp_q[j].size() < DEPTH);
      vld = (dn_exp_q[j].size() != 0);
      if (vld && dn_ack[j]) void'(dn_exp_q[j].pop_front());
      if (core_val_out[j] && rdy) begin
        dn_exp_q[j].push_back(core_dout[j*W +: W]);
        void'(dn_src_q[j].pop_front());
      end
    end
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: if (ap_start) m_mode = M_RUN;
      M_RUN: if (!ap_start) begin m_mode = M_DRAIN; m_quiet = 0; end
      default: begin
        if (ap_start) begin
          m_mode = M_RUN; m_quiet = 0;
        end else if (!quiet) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == DRAIN) begin m_mode = M_IDLE; m_done = 1'b1; m_quiet = 0; end
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; sources present the head of their queue and
  // hold it until the model records the transfer.
  task automatic step();
    for (int i = 0; i < NI; i++) begin
      up_vld[i] = (up_src_q[i].size() != 0);
      up_din[i*W +: W] = up_vld[i] ? up_src_q[i][0] : '0;
    end
    for (int j = 0; j < NO; j++) begin
      core_val_out[j] = (dn_src_q[j].size() != 0);
      core_dout[j*W +: W] = core_val_out[j] ? dn_src_q[j][0] : '0;
    end
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    ap_start = 1'b0;
    dn_ack = '1;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
    check(tag, done, 1'b1);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start_cyc;
    logic any_done;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_core_resetn", core_resetn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_up_ack", up_ack, '0);
    check("rst_core_val_in", core_val_in, '0);
    check("rst_core_ready_dn", core_ready_downward, '0);
    check("rst_dn_vld", dn_vld, '0);
    check("rst_dn_dout", dn_dout, '0);
    check("rst_state", state_dbg, ST_IDLE);
    resetn = 1'b1;

    // Start latency and first upstream word.
    steps(5);
    ap_start = 1'b1;
    step();
    check("start_core_resetn", core_resetn, 1'b1);
    check("start_busy", busy, 1'b1);
    up_src_q[0].push_back(32'hDEADBEEF);
    step();
    check("first_val_in", core_val_in[0], 1'b1);
    check("first_core_din", core_din[W-1:0], 32'hDEADBEEF);
    core_ready_upward = '1;
    step();
    core_ready_upward = '0;
    wait_done("done_after_first", 60);

    // IDLE preload: four words fit, the fifth waits for RUN.
    core_ready_upward = '1;
    for (int k = 0; k < 5; k++) up_src_q[0].push_back(32'h1000_0000 + k);
    steps(6);
    check("preload_ack_full", up_ack[0], 1'b0);
    check("preload_no_val", core_val_in[0], 1'b0);
    check("preload_head", core_din[W-1:0], 32'h1000_0000);
    ap_start = 1'b1;
    steps(10);
    check("preload_drained", core_val_in[0], 1'b0);

    // Downstream backpressure on ch1 while ch0 keeps flowing.
    dn_ack = 2'b01;
    for (int k = 0; k < 6; k++) begin
      dn_src_q[1].push_back(32'hB000_0000 + k);
      dn_src_q[0].push_back(32'hA000_0000 + k);
    end
    steps(7);
    check("bp_ch1_full", core_ready_downward[1], 1'b0);
    check("bp_ch0_ready", core_ready_downward[0], 1'b1);
    check("bp_ch1_head", dn_dout[2*W-1:W], 32'hB000_0000);
    // Full FIFO with simultaneous pop and offered push: only the pop happens.
    dn_ack = 2'b11;
    step();
    check("full_pp_ready", core_ready_downward[1], 1'b1);
    check("full_pp_head", dn_dout[2*W-1:W], 32'hB000_0001);
    steps(8);
    check("bp_flushed", dn_vld, '0);

    // Drain timing: done arrives DRAIN cycles after the last word leaves.
    dn_ack = '0;
    dn_src_q[0].push_back(32'hC0DE_0001);
    dn_src_q[0].push_back(32'hC0DE_0002);
    steps(3);
    ap_start = 1'b0;
    dn_ack = '1;
    for (int n = 0; n < 10 && dn_vld != '0; n++) step();
    check("drain_emptied", dn_vld, '0);
    start_cyc = cyc;
    for (int n = 0; n < 40 && done !== 1'b1; n++) step();
    check("drain_len", cyc - start_cyc, DRAIN);
    check("drain_core_resetn", core_resetn, 1'b0);
    step();

    // Restart from DRAIN before the idle count completes: no done.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    step();
    any_done = 1'b0;
    for (int n = 0; n < 10; n++) begin any_done |= done; step(); end
    ap_start = 1'b1;
    for (int n = 0; n < 20; n++) begin any_done |= done; step(); end
    check("abort_no_done", any_done, 1'b0);
    check("abort_busy", busy, 1'b1);

    // Asynchronous reset with buffered words.
    dn_ack = '0;
    core_ready_upward = '0;
    for (int k = 0; k < 3; k++) dn_src_q[0].push_back(32'hE000_0000 + k);
    up_src_q[0].push_back(32'h5555_AAAA);
    steps(4);
    #2 resetn = 1'b0;
    #1;
    check("arst_dn_vld", dn_vld, '0);
    check("arst_core_val_in", core_val_in, '0);
    check("arst_up_ack", up_ack, '0);
    check("arst_busy", busy, 1'b0);
    model_reset();
    ap_start = 1'b0;
    up_vld = '0;
    core_val_out = '0;
    @(negedge clk);
    resetn = 1'b1;
    dn_ack = '1;
    steps(3);
    check("arst_no_stale", dn_vld, '0);

    // Randomized traffic with occasional run/stop toggling.
    ap_start = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) ap_start = ~ap_start;
      core_ready_upward = NI'($urandom);
      dn_ack = NO'($urandom);
      for (int i = 0; i < NI; i++)
        if (up_src_q[i].size() < 3 && $urandom_range(0, 2) != 0) up_src_q[i].push_back($urandom);
      for (int j = 0; j < NO; j++)
        if (dn_src_q[j].size() < 3 && $urandom_range(0, 2) != 0) dn_src_q[j].push_back($urandom);
      step();
    end
    ap_start = 1'b1;
    core_ready_upward = '1;
    dn_ack = '1;
    steps(40);
    wait_done("random_final_done", 200);
    check("random_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
